// File: rtl/tft_display_timing.sv
// Raster timing generator for the 480x272 TFT panel on the 9 MHz pixel clock.
// Free-running h/v counters produce raw sync/DE and the active-area coordinates
// fed to the glyph renderer. Raw sync/DE are delayed to match the renderer
// latency, then registered together with glyph_data so every panel signal
// leaves the chip on the same edge.
module tft_display_timing #(
    parameter int H_SYNC     = 41,
    parameter int H_BACK     = 2,
    parameter int H_VALID    = 480,
    parameter int H_FRONT    = 2,
    parameter int V_SYNC     = 10,
    parameter int V_BACK     = 2,
    parameter int V_VALID    = 272,
    parameter int V_FRONT    = 2,
    parameter int PIPE_DELAY = 3
) (
    input  logic        tft_clock_9m,
    input  logic        system_reset_n,
    input  logic [15:0] glyph_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic        tft_hsync,
    output logic        tft_vsync,
    output logic        tft_de,
    output logic [15:0] tft_rgb,
    output logic        tft_backlight
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_VALID);
    localparam logic [9:0] OUTSIDE     = 10'h3FF;

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;

    logic       hs_raw;
    logic       vs_raw;
    logic       de_raw;
    logic       h_active;
    logic       v_active;

    // Flag delay lines; the top bit lines up with glyph_data for the same pixel.
    logic [PIPE_DELAY-1:0] hs_pipe;
    logic [PIPE_DELAY-1:0] vs_pipe;
    logic [PIPE_DELAY-1:0] de_pipe;
    logic                  hs_d;
    logic                  vs_d;
    logic                  de_d;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Raster position: h_cnt every clock, v_cnt once per line, both wrap at frame end.
    always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
        if (!system_reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Raw timing and renderer coordinates straight from the counters.
    always_comb begin
        hs_raw   = (h_cnt >= H_SYNC_END);
        vs_raw   = (v_cnt >= V_SYNC_END);
        h_active = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
        v_active = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
        de_raw   = h_active && v_active;
        pix_x    = de_raw ? (h_cnt - H_ACT_START) : OUTSIDE;
        pix_y    = de_raw ? (v_cnt - V_ACT_START) : OUTSIDE;
    end

    // Match renderer latency; reset flushes to idle levels so no partial DE escapes.
    always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
        if (!system_reset_n) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
            de_pipe <= '0;
        end else begin
            hs_pipe <= {hs_pipe[PIPE_DELAY-2:0], hs_raw};
            vs_pipe <= {vs_pipe[PIPE_DELAY-2:0], vs_raw};
            de_pipe <= {de_pipe[PIPE_DELAY-2:0], de_raw};
        end
    end

    assign hs_d = hs_pipe[PIPE_DELAY-1];
    assign vs_d = vs_pipe[PIPE_DELAY-1];
    assign de_d = de_pipe[PIPE_DELAY-1];

    // Panel output register; glyph_data is gated so blanking never carries renderer junk.
    always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
        if (!system_reset_n) begin
            tft_hsync <= 1'b1;
            tft_vsync <= 1'b1;
            tft_de    <= 1'b0;
            tft_rgb   <= 16'h0000;
        end else begin
            tft_hsync <= hs_d;
            tft_vsync <= vs_d;
            tft_de    <= de_d;
            tft_rgb   <= de_d ? glyph_data : 16'h0000;
        end
    end

    // Frame marker (undelayed) and backlight enable that comes up once reset is gone.
    always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
        if (!system_reset_n) begin
            frame_start   <= 1'b0;
            tft_backlight <= 1'b0;
        end else begin
            frame_start   <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            tft_backlight <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tft_display_timing.sv
// Bench for tft_display_timing. Horizontal timing is the real 525-clock line;
// the vertical active area is shortened to 16 lines (30-line frame, 15750
// clocks) so whole frames fit in a short run. A reference raster model pushes
// expected pixels into a scoreboard; a negedge monitor pops them whenever the
// panel shows DE and also checks sync widths, spacing and frame_start.
module tb_tft_display_timing;

    localparam int H_SYNC  = 41;
    localparam int H_BACK  = 2;
    localparam int H_VALID = 480;
    localparam int H_FRONT = 2;
    localparam int V_SYNC  = 10;
    localparam int V_BACK  = 2;
    localparam int V_VALID = 16;
    localparam int V_FRONT = 2;
    localparam int PIPE    = 3;
    localparam int H_TOTAL = 525;
    localparam int V_TOTAL = 30;
    localparam int FRAME   = 15750;

    logic        tft_clock_9m;
    logic        system_reset_n;
    logic [15:0] glyph_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;
    logic        tft_hsync;
    logic        tft_vsync;
    logic        tft_de;
    logic [15:0] tft_rgb;
    logic        tft_backlight;

    tft_display_timing #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_VALID(H_VALID), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_VALID(V_VALID), .V_FRONT(V_FRONT),
        .PIPE_DELAY(PIPE)
    ) dut (
        .tft_clock_9m  (tft_clock_9m),
        .system_reset_n(system_reset_n),
        .glyph_data    (glyph_data),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .frame_start   (frame_start),
        .tft_hsync     (tft_hsync),
        .tft_vsync     (tft_vsync),
        .tft_de        (tft_de),
        .tft_rgb       (tft_rgb),
        .tft_backlight (tft_backlight)
    );

    int n_cmp;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    initial begin
        tft_clock_9m = 1'b0;
        forever #55 tft_clock_9m = ~tft_clock_9m;
    end

    // Renderer model: glyph_data is pix_x from three clocks earlier.
    logic [9:0] rd1, rd2, rd3;
    initial begin
        glyph_data = 16'h0000;
        rd1 = 10'h3FF;
        rd2 = 10'h3FF;
        rd3 = 10'h3FF;
        forever begin
            @(posedge tft_clock_9m);
            #1;
            glyph_data = {6'd0, rd3};
            rd3 = rd2;
            rd2 = rd1;
            rd1 = pix_x;
        end
    end

    // Reference raster model, stepped on each rising edge.
    int         mh, mv;
    logic [2:0] hist[$];
    logic [15:0] exp_q[$];
    logic [2:0] e_flags;
    logic [9:0] e_px, e_py;
    logic       e_fs;

    always @(posedge tft_clock_9m) begin
        logic hs, vs, de;
        logic [9:0] xv;
        if (!system_reset_n) begin
            mh = 0;
            mv = 0;
            hist.delete();
            repeat (PIPE + 1) hist.push_back(3'b110);
            exp_q.delete();
            e_fs = 1'b0;
        end else begin
            e_fs = (mh == 0) && (mv == 0);
            hs = (mh >= 41);
            vs = (mv >= 10);
            de = (mh >= 43) && (mh < 523) && (mv >= 12) && (mv < 28);
            if (de) begin
                xv = 10'(mh - 43);
                exp_q.push_back({6'd0, xv});
            end
            hist.push_back({hs, vs, de});
            void'(hist.pop_front());
            if (mh == H_TOTAL - 1) begin
                mh = 0;
                mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        e_flags = hist[0];
        if ((mh >= 43) && (mh < 523) && (mv >= 12) && (mv < 28)) begin
            e_px = 10'(mh - 43);
            e_py = 10'(mv - 12);
        end else begin
            e_px = 10'h3FF;
            e_py = 10'h3FF;
        end
    end

    // Monitor: compares every cycle and pops the scoreboard on each DE pixel.
    int   mon_cyc, last_fs, hs_fall, hs_run, vs_run, de_run, de_lines;
    logic prev_hs, prev_vs, prev_de, fs_seen, de_seen, v_seen;
    logic [15:0] want_rgb;

    always @(negedge tft_clock_9m) begin
        if (!system_reset_n) begin
            check("rst_pix_x", 32'(pix_x), 32'h3FF);
            check("rst_pix_y", 32'(pix_y), 32'h3FF);
            check("rst_hsync", 32'(tft_hsync), 32'd1);
            check("rst_vsync", 32'(tft_vsync), 32'd1);
            check("rst_de", 32'(tft_de), 32'd0);
            check("rst_rgb", 32'(tft_rgb), 32'd0);
            check("rst_frame_start", 32'(frame_start), 32'd0);
            check("rst_backlight", 32'(tft_backlight), 32'd0);
            mon_cyc  = 0;
            last_fs  = 0;
            hs_fall  = 0;
            hs_run   = 0;
            vs_run   = 0;
            de_run   = 0;
            de_lines = 0;
            prev_hs  = 1'b1;
            prev_vs  = 1'b1;
            prev_de  = 1'b0;
            fs_seen  = 1'b0;
            de_seen  = 1'b0;
            v_seen   = 1'b0;
        end else begin
            mon_cyc++;
            check("pix_x", 32'(pix_x), 32'(e_px));
            check("pix_y", 32'(pix_y), 32'(e_py));
            check("hsync", 32'(tft_hsync), 32'(e_flags[2]));
            check("vsync", 32'(tft_vsync), 32'(e_flags[1]));
            check("de", 32'(tft_de), 32'(e_flags[0]));
            check("frame_start", 32'(frame_start), 32'(e_fs));
            check("backlight", 32'(tft_backlight), 32'd1);

            if (tft_de === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_now("scoreboard_empty");
                end else begin
                    want_rgb = exp_q.pop_front();
                    check("rgb", 32'(tft_rgb), 32'(want_rgb));
                end
            end else begin
                check("rgb_blank", 32'(tft_rgb), 32'd0);
            end

            if (frame_start === 1'b1) begin
                if (!fs_seen) check("first_fs_cycle", 32'(mon_cyc), 32'd1);
                else          check("fs_period", 32'(mon_cyc - last_fs), 32'(FRAME));
                fs_seen = 1'b1;
                last_fs = mon_cyc;
            end

            if (prev_hs && !tft_hsync) hs_fall = mon_cyc;
            if (!tft_hsync) hs_run++;
            else begin
                if (!prev_hs) check("hsync_width", 32'(hs_run), 32'd41);
                hs_run = 0;
            end

            if (prev_vs && !tft_vsync) begin
                if (v_seen) check("de_lines_per_frame", 32'(de_lines), 32'd16);
                v_seen   = 1'b1;
                de_lines = 0;
            end
            if (!tft_vsync) vs_run++;
            else begin
                if (!prev_vs) check("vsync_width", 32'(vs_run), 32'(10 * H_TOTAL));
                vs_run = 0;
            end

            if (tft_de) begin
                if (!prev_de) begin
                    de_lines++;
                    check("hsync_fall_to_de", 32'(mon_cyc - hs_fall), 32'd43);
                    if (!de_seen) check("first_de_cycle", 32'(mon_cyc), 32'(12 * 525 + 43 + PIPE + 1));
                    de_seen = 1'b1;
                end
                de_run++;
            end else begin
                if (prev_de) check("de_width", 32'(de_run), 32'd480);
                de_run = 0;
            end

            prev_hs = tft_hsync;
            prev_vs = tft_vsync;
            prev_de = tft_de;
        end
    end

    // Directed sequence: power-on reset, one full frame, mid-frame reset, recovery.
    initial begin
        bit found;
        n_cmp  = 0;
        n_fail = 0;
        system_reset_n = 1'b0;
        repeat (3) @(negedge tft_clock_9m);
        #1 system_reset_n = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge tft_clock_9m);
            #1;
            if (fs_seen && (last_fs > 1) && (mv == 20) && (mh == 200)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("reach_reset_point");

        check("pre_rst_de", 32'(tft_de), 32'd1);
        system_reset_n = 1'b0;
        #1;
        check("async_rst_de", 32'(tft_de), 32'd0);
        check("async_rst_rgb", 32'(tft_rgb), 32'd0);
        check("async_rst_pix_x", 32'(pix_x), 32'h3FF);
        check("async_rst_pix_y", 32'(pix_y), 32'h3FF);
        check("async_rst_hsync", 32'(tft_hsync), 32'd1);
        check("async_rst_backlight", 32'(tft_backlight), 32'd0);
        repeat (5) @(negedge tft_clock_9m);
        #1 system_reset_n = 1'b1;

        found = 1'b0;
        for (int i = 1; i <= 8000; i++) begin
            @(negedge tft_clock_9m);
            #1;
            if (pix_x !== 10'h3FF) begin
                check("post_rst_first_active_cycle", 32'(i), 32'(12 * 525 + 43));
                check("post_rst_first_pix_x", 32'(pix_x), 32'd0);
                check("post_rst_first_pix_y", 32'(pix_y), 32'd0);
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("post_rst_active");

        repeat (502) @(negedge tft_clock_9m);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
